// File: rtl/sqed_dup_issue_queue.sv
// SQED duplicate issue queue: forwards originals, buffers their register-offset duplicates
// and drains them in program order. Optional macro SQED_DUP_CNT_EN adds issue counters and qed_ready.
module sqed_dup_issue_queue #(
    parameter int          DEPTH      = 8,
    parameter int          REG_OFFSET = 12,
    parameter logic [11:0] MEM_OFFSET = 12'h008
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [31:0]                in_instruction,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_instruction,
    output logic                       out_is_dup,
    input  logic                       out_ready,
    input  logic                       exec_dup,
    output logic [$clog2(DEPTH):0]     dup_pending,
    output logic                       state_drain
`ifdef SQED_DUP_CNT_EN
    ,
    output logic [15:0]                orig_cnt,
    output logic [15:0]                dup_cnt,
    output logic                       qed_ready
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [4:0]    ROFF     = 5'(REG_OFFSET);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

    typedef enum logic [0:0] {ST_ORIG = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t        state_r, state_s;
    logic          init_done_r;
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_s;
    logic [31:0]   fifo_mem_r [DEPTH];
    logic          out_valid_r, out_is_dup_r;
    logic [31:0]   out_instr_r;
    logic          slot_free_s, full_s, empty_s, in_ready_s, accept_s, push_s, pop_s;

    function automatic logic [4:0] off_reg(input logic [4:0] r);
        return (r == 5'd0) ? 5'd0 : (r + ROFF);
    endfunction

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b0110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] make_dup(input logic [31:0] ins);
        logic [11:0] m_ld, m_st;
        m_ld = MEM_OFFSET | {9'd0, ins[22:20]};
        m_st = MEM_OFFSET | {9'd0, ins[9:7]};
        case (ins[6:0])
            7'b0010011: return {ins[31:20], off_reg(ins[19:15]), ins[14:12], off_reg(ins[11:7]), ins[6:0]};
            7'b0000011: return {m_ld, ins[19:15], ins[14:12], off_reg(ins[11:7]), ins[6:0]};
            7'b0110011: return {ins[31:25], off_reg(ins[24:20]), off_reg(ins[19:15]), ins[14:12],
                                off_reg(ins[11:7]), ins[6:0]};
            7'b0100011: return {m_st[11:5], off_reg(ins[24:20]), ins[19:15], ins[14:12], m_st[4:0], ins[6:0]};
            7'b1100011: return {ins[31:25], off_reg(ins[24:20]), off_reg(ins[19:15]), ins[14:12],
                                ins[11:7], ins[6:0]};
            7'b0110111, 7'b0010111, 7'b1101111:
                        return {ins[31:12], off_reg(ins[11:7]), ins[6:0]};
            7'b1100111: return {ins[31:20], off_reg(ins[19:15]), 3'b000, off_reg(ins[11:7]), ins[6:0]};
            default:    return ins;
        endcase
    endfunction

    assign slot_free_s = !out_valid_r || out_ready;
    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == {CW{1'b0}});
    // in_ready stays low until the first edge after reset release
    assign in_ready_s  = init_done_r && (state_r == ST_ORIG) && slot_free_s && !full_s;
    assign accept_s    = in_valid && in_ready_s;
    assign push_s      = accept_s && is_supported(in_instruction[6:0]);
    assign pop_s       = (state_r == ST_DRAIN) && slot_free_s && !empty_s;

    // Occupancy after this edge's push or pop and the resulting next state
    always_comb begin
        count_s = count_r;
        state_s = state_r;
        if (push_s) begin
            count_s = count_r + CNT_ONE;
        end else if (pop_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
        case (state_r)
            ST_ORIG: begin
                if ((count_s == CNT_FULL) || (exec_dup && (count_s != {CW{1'b0}}))) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ORIG;
                end
            end
            ST_DRAIN: begin
                if (count_s == {CW{1'b0}}) begin
                    state_s = ST_ORIG;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_ORIG;
        endcase
    end

    // Control state, pointers, occupancy and the output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ORIG;
            init_done_r  <= 1'b0;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            out_valid_r  <= 1'b0;
            out_instr_r  <= 32'h00000013;
            out_is_dup_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_done_r <= 1'b1;
            count_r     <= count_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (accept_s) begin
                out_valid_r  <= 1'b1;
                out_instr_r  <= in_instruction;
                out_is_dup_r <= 1'b0;
            end else if (pop_s) begin
                out_valid_r  <= 1'b1;
                out_instr_r  <= fifo_mem_r[rd_ptr_r];
                out_is_dup_r <= 1'b1;
            end else if (slot_free_s) begin
                out_valid_r  <= 1'b0;
            end
        end
    end

    // Duplicate storage; contents are only meaningful below the occupancy count
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= make_dup(in_instruction);
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = out_valid_r;
    assign out_instruction = out_instr_r;
    assign out_is_dup      = out_is_dup_r;
    assign dup_pending     = count_r;
    assign state_drain     = (state_r == ST_DRAIN);

`ifdef SQED_DUP_CNT_EN
    logic [15:0] orig_cnt_r, dup_cnt_r;

    // Issued originals and duplicates, counted at the output handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            orig_cnt_r <= 16'd0;
            dup_cnt_r  <= 16'd0;
        end else if (out_valid_r && out_ready) begin
            if (out_is_dup_r) begin
                dup_cnt_r <= dup_cnt_r + 16'd1;
            end else begin
                orig_cnt_r <= orig_cnt_r + 16'd1;
            end
        end
    end

    assign orig_cnt  = orig_cnt_r;
    assign dup_cnt   = dup_cnt_r;
    assign qed_ready = (state_r == ST_ORIG) && empty_s && !out_valid_r && (orig_cnt_r == dup_cnt_r);
`endif

endmodule

// File: tb/tb_sqed_dup_issue_queue.sv
// Scoreboard bench for sqed_dup_issue_queue (DEPTH=4): directed instructions with
// hand-encoded duplicates, checked by an output monitor against an expectation queue.
module tb_sqed_dup_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_is_dup, out_ready, exec_dup, state_drain;
    logic [31:0] in_instruction, out_instruction;
    logic [2:0]  dup_pending;
`ifdef SQED_DUP_CNT_EN
    logic [15:0] orig_cnt, dup_cnt;
    logic        qed_ready;
`endif

    int checks   = 0;
    int failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] dup_q[$];
    logic [31:0] held;

    always #5 clk = ~clk;

    sqed_dup_issue_queue #(.DEPTH(4), .REG_OFFSET(12), .MEM_OFFSET(12'h008)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instruction(in_instruction),
        .in_ready(in_ready), .out_valid(out_valid), .out_instruction(out_instruction),
        .out_is_dup(out_is_dup), .out_ready(out_ready), .exec_dup(exec_dup),
        .dup_pending(dup_pending), .state_drain(state_drain)
`ifdef SQED_DUP_CNT_EN
        , .orig_cnt(orig_cnt), .dup_cnt(dup_cnt), .qed_ready(qed_ready)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer is compared with the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if (dup_pending > 3'd4) begin
                failures++;
                $display("FAIL fifo_bound: dup_pending %0d exceeds 4", dup_pending);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %h dup=%0d with empty scoreboard",
                             out_instruction, out_is_dup);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("out_instruction", out_instruction, e[31:0]);
                    check("out_is_dup", {31'd0, out_is_dup}, {31'd0, e[32]});
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] dup, input bit has_dup);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_instruction = ins;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready never high for %h", ins);
        end else begin
            exp_q.push_back({1'b0, ins});
            if (has_dup) dup_q.push_back({1'b1, dup});
        end
    endtask

    task automatic flush();
        while (dup_q.size() > 0) exp_q.push_back(dup_q.pop_front());
    endtask

    task automatic pulse_exec();
        flush();
        exec_dup = 1'b1;
        @(posedge clk);
        #1;
        exec_dup = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 200 && !(exp_q.size() == 0 && dup_pending == 3'd0 && !state_drain && !out_valid)) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s_timeout: pending=%0d queued=%0d expected idle", name, dup_pending, exp_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instruction = 32'd0; out_ready = 1'b1; exec_dup = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instruction", out_instruction, 32'h00000013);
        check("rst_out_is_dup", {31'd0, out_is_dup}, 32'd0);
        check("rst_dup_pending", {29'd0, dup_pending}, 32'd0);
        check("rst_state_drain", {31'd0, state_drain}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

        // addi x1,x2,5 then exec_dup
        send(32'h00510093, 32'h00570693, 1'b1);
        pulse_exec();
        check("exec_enters_drain", {31'd0, state_drain}, 32'd1);
        wait_idle("addi");

        // nop keeps x0
        send(32'h00000013, 32'h00000013, 1'b1);
        pulse_exec();
        wait_idle("nop");

        // lw x3,4(x5)
        send(32'h0042A183, 32'h00C2A783, 1'b1);
        pulse_exec();
        wait_idle("lw");

        // Fill the FIFO: add, sw, beq, lui
        send(32'h003100B3, 32'h00F706B3, 1'b1);
        send(32'h0063A423, 32'h0123A423, 1'b1);
        send(32'h00208863, 32'h00E68863, 1'b1);
        send(32'h123452B7, 32'h123458B7, 1'b1);
        flush();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_pending", {29'd0, dup_pending}, 32'd4);
        check("full_drain", {31'd0, state_drain}, 32'd1);
        wait_idle("fill");
        check("after_fill_in_ready", {31'd0, in_ready}, 32'd1);
        check("after_fill_pending", {29'd0, dup_pending}, 32'd0);

        // fence: no duplicate, exec_dup ignored
        send(32'h0000000F, 32'h0, 1'b0);
        pulse_exec();
        check("fence_no_drain", {31'd0, state_drain}, 32'd0);
        check("fence_pending", {29'd0, dup_pending}, 32'd0);
        wait_idle("fence");

        // Backpressure in DRAIN; jalr with funct3=001 gets funct3 forced to 000
        send(32'h00510093, 32'h00570693, 1'b1);
        send(32'h000110E7, 32'h000706E7, 1'b1);
        pulse_exec();
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_dup", out_instruction, 32'h00570693);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_instr", out_instruction, 32'h00570693);
            check("bp_hold_is_dup", {31'd0, out_is_dup}, 32'd1);
            check("bp_hold_drain", {31'd0, state_drain}, 32'd1);
        end
        out_ready = 1'b1;
        wait_idle("backpressure");

        // Reset with three duplicates pending and an original stuck in the slot
        send(32'h00000013, 32'h00000013, 1'b1);
        send(32'h00510093, 32'h00570693, 1'b1);
        send(32'h0042A183, 32'h00C2A783, 1'b1);
        out_ready = 1'b0;
        check("pre_rst_pending", {29'd0, dup_pending}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_pending", {29'd0, dup_pending}, 32'd0);
        check("mid_rst_drain", {31'd0, state_drain}, 32'd0);
        exp_q.delete();
        dup_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h00510093, 32'h00570693, 1'b1);
        pulse_exec();
        wait_idle("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
